// File: rtl/ram_access_unit_pkg.sv
// Shared RAM access codes and FSM encoding for the internal data RAM stage.
package ram_access_unit_pkg;

  // RAM access codes emitted by control_unit. Codes 8..15 behave as RAM_NONE.
  typedef enum logic [3:0] {
    RAM_NONE       = 4'd0,
    RD_RAM_REG     = 4'd1,
    WR_RAM_REG     = 4'd2,
    RD_RAM_REG_IND = 4'd3,
    WR_RAM_REG_IND = 4'd4,
    RD_RAM_DIRECT  = 4'd5,
    RD_RAM_IM      = 4'd6,
    WR_RAM_DIRECT  = 4'd7
  } ram_access_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PTR_RD   = 3'd1,
    S_PTR_WAIT = 3'd2,
    S_RD       = 3'd3,
    S_RD_WAIT  = 3'd4,
    S_WR       = 3'd5,
    S_DONE     = 3'd6
  } ram_state_e;

  // Rn lives at {bank, n}; the @Ri pointer is R0 or R1 of the active bank.
  function automatic logic [4:0] reg_byte_addr(input logic [1:0] bank, input logic [2:0] rsel);
    return {bank, rsel};
  endfunction

  function automatic logic [4:0] ptr_byte_addr(input logic [1:0] bank, input logic [2:0] rsel);
    return {bank, 2'b00, rsel[0]};
  endfunction

endpackage

// File: rtl/ram_access_unit.sv
// Operand / data-memory stage: performs one internal-RAM transaction per request
// and hands the operand byte back to the ALU path.
module ram_access_unit
  import ram_access_unit_pkg::*;
#(
  parameter int unsigned RAM_AW = 7,
  parameter int unsigned DW     = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        ram_access,
  input  logic [1:0]        bank_sel,
  input  logic [2:0]        reg_sel,
  input  logic [7:0]        direct_addr,
  input  logic [DW-1:0]     imm_data,
  input  logic [DW-1:0]     acc_in,
  input  logic [DW-1:0]     ram_rdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic [DW-1:0]     ram_wdata,
  output logic [DW-1:0]     operand,
  output logic              busy,
  output logic              done,
  output logic              addr_err
);

  ram_state_e        state_q, state_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW-1:0]     operand_q, operand_d;
  logic              err_q, err_d;
  logic              ind_wr_q, ind_wr_d;
  ram_access_e       code;
  logic              ptr_out_of_range;

  assign code = ram_access_e'(ram_access);

  // Pointer bytes at or above the RAM size would alias into SFR space.
  assign ptr_out_of_range = ((ram_rdata >> RAM_AW) != '0);

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      operand_q <= '0;
      err_q     <= 1'b0;
      ind_wr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      operand_q <= operand_d;
      err_q     <= err_d;
      ind_wr_q  <= ind_wr_d;
    end
  end

  // Next-state and datapath update; the address only moves on entry to a strobe state.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    operand_d = operand_q;
    err_d     = err_q;
    ind_wr_d  = ind_wr_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          case (code)
            RD_RAM_IM: begin
              operand_d = imm_data;
              state_d   = S_DONE;
            end
            RD_RAM_REG: begin
              addr_d  = RAM_AW'(reg_byte_addr(bank_sel, reg_sel));
              state_d = S_RD;
            end
            WR_RAM_REG: begin
              addr_d  = RAM_AW'(reg_byte_addr(bank_sel, reg_sel));
              wdata_d = acc_in;
              state_d = S_WR;
            end
            RD_RAM_DIRECT: begin
              if (direct_addr[7]) begin
                // SFR space is served elsewhere; flag and finish without a strobe.
                err_d     = 1'b1;
                operand_d = '0;
                state_d   = S_DONE;
              end else begin
                addr_d  = RAM_AW'(direct_addr);
                state_d = S_RD;
              end
            end
            WR_RAM_DIRECT: begin
              if (direct_addr[7]) begin
                err_d     = 1'b1;
                operand_d = '0;
                state_d   = S_DONE;
              end else begin
                addr_d  = RAM_AW'(direct_addr);
                wdata_d = acc_in;
                state_d = S_WR;
              end
            end
            RD_RAM_REG_IND, WR_RAM_REG_IND: begin
              addr_d   = RAM_AW'(ptr_byte_addr(bank_sel, reg_sel));
              wdata_d  = acc_in;
              ind_wr_d = (code == WR_RAM_REG_IND);
              state_d  = S_PTR_RD;
            end
            default: begin
              state_d = S_DONE;
            end
          endcase
        end
      end

      S_PTR_RD: begin
        state_d = S_PTR_WAIT;
      end

      S_PTR_WAIT: begin
        if (ptr_out_of_range) begin
          err_d     = 1'b1;
          operand_d = '0;
          state_d   = S_DONE;
        end else begin
          addr_d  = RAM_AW'(ram_rdata);
          state_d = ind_wr_q ? S_WR : S_RD;
        end
      end

      S_RD: begin
        state_d = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        operand_d = ram_rdata;
        state_d   = S_DONE;
      end

      S_WR: begin
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes decode straight from state so reset kills them combinationally.
  always_comb begin
    ram_rd    = (state_q == S_PTR_RD) || (state_q == S_RD);
    ram_wr    = (state_q == S_WR);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    operand   = operand_q;
    addr_err  = err_q;
  end

endmodule

// File: tb/tb_ram_access_unit.sv
// Self-checking bench for ram_access_unit: directed scenarios plus random
// transactions checked against an arithmetic model of the internal RAM.
module tb_ram_access_unit;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] ram_access = 4'd0;
  logic [1:0] bank_sel = 2'd0;
  logic [2:0] reg_sel = 3'd0;
  logic [7:0] direct_addr = 8'd0;
  logic [7:0] imm_data = 8'd0;
  logic [7:0] acc_in = 8'd0;
  logic [7:0] ram_rdata = 8'd0;
  logic [6:0] ram_addr;
  logic       ram_rd;
  logic       ram_wr;
  logic [7:0] ram_wdata;
  logic [7:0] operand;
  logic       busy;
  logic       done;
  logic       addr_err;

  int tests = 0;
  int fails = 0;

  // Backdoor preload port into the RAM model.
  logic       bd_we = 1'b0;
  logic [6:0] bd_addr = 7'd0;
  logic [7:0] bd_data = 8'd0;

  logic [7:0] mem    [128];
  logic [7:0] shadow [128];

  // Reference state carried between transactions.
  logic [7:0] exp_operand = 8'd0;
  logic [7:0] first_rd_addr;

  ram_access_unit #(.RAM_AW(7), .DW(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .ram_access (ram_access),
    .bank_sel   (bank_sel),
    .reg_sel    (reg_sel),
    .direct_addr(direct_addr),
    .imm_data   (imm_data),
    .acc_in     (acc_in),
    .ram_rdata  (ram_rdata),
    .ram_addr   (ram_addr),
    .ram_rd     (ram_rd),
    .ram_wr     (ram_wr),
    .ram_wdata  (ram_wdata),
    .operand    (operand),
    .busy       (busy),
    .done       (done),
    .addr_err   (addr_err)
  );

  always #5 clock = ~clock;

  // Single-port RAM with one cycle of read latency.
  always @(posedge clock) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_wr) mem[ram_addr] <= ram_wdata;
    if (ram_rd) ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [6:0] a, input logic [7:0] d);
    bd_we = 1'b1;
    bd_addr = a;
    bd_data = d;
    shadow[a] = d;
    @(posedge clock);
    #1;
    bd_we = 1'b0;
  endtask

  // Behavioural model: what the transaction should do, computed from the access rules.
  task automatic model(input logic [3:0] c, input logic [1:0] bank, input logic [2:0] rs,
                       input logic [7:0] da, input logic [7:0] im, input logic [7:0] acc,
                       output logic [7:0] op, output logic err, output int lat,
                       output int nrd, output int nwr, output int waddr, output logic [7:0] wd);
    int ra;
    int pl;
    int p;
    ra = bank * 8 + rs;
    pl = bank * 8 + (rs % 2);
    op = exp_operand;
    err = 1'b0;
    lat = 1;
    nrd = 0;
    nwr = 0;
    waddr = 0;
    wd = 8'd0;
    case (c)
      4'd6: op = im;
      4'd1: begin op = shadow[ra]; lat = 3; nrd = 1; end
      4'd2: begin shadow[ra] = acc; lat = 2; nwr = 1; waddr = ra; wd = acc; end
      4'd5, 4'd7: begin
        if (da >= 128) begin
          err = 1'b1;
          op = 8'd0;
        end else if (c == 4'd5) begin
          op = shadow[da[6:0]]; lat = 3; nrd = 1;
        end else begin
          shadow[da[6:0]] = acc; lat = 2; nwr = 1; waddr = da; wd = acc;
        end
      end
      4'd3, 4'd4: begin
        p = shadow[pl];
        nrd = 1;
        if (p >= 128) begin
          err = 1'b1; op = 8'd0; lat = 3;
        end else if (c == 4'd3) begin
          op = shadow[p]; lat = 5; nrd = 2;
        end else begin
          shadow[p] = acc; lat = 4; nwr = 1; waddr = p; wd = acc;
        end
      end
      default: ;
    endcase
    exp_operand = op;
  endtask

  // Issue one request and follow it to done, then compare with the model.
  task automatic run(input string tag, input logic [3:0] c, input logic [1:0] bank,
                     input logic [2:0] rs, input logic [7:0] da, input logic [7:0] im,
                     input logic [7:0] acc, input bit hammer);
    logic [7:0] e_op;
    logic       e_err;
    int         e_lat, e_rd, e_wr, e_waddr;
    logic [7:0] e_wd;
    int         cyc, nrd, nwr, both, obs_waddr;
    logic [7:0] obs_wd;
    bit         seen;
    model(c, bank, rs, da, im, acc, e_op, e_err, e_lat, e_rd, e_wr, e_waddr, e_wd);
    ram_access = c; bank_sel = bank; reg_sel = rs;
    direct_addr = da; imm_data = im; acc_in = acc;
    start = 1'b1;
    @(posedge clock);
    #1;
    if (!hammer) start = 1'b0;
    cyc = 1; nrd = 0; nwr = 0; both = 0; obs_waddr = 0; obs_wd = 8'd0;
    seen = 1'b0; first_rd_addr = 8'hFF;
    while (cyc <= 20) begin
      if (ram_rd) begin
        if (nrd == 0) first_rd_addr = {1'b0, ram_addr};
        nrd++;
      end
      if (ram_wr) begin nwr++; obs_waddr = ram_addr; obs_wd = ram_wdata; end
      if (ram_rd && ram_wr) both++;
      if (done) begin seen = 1'b1; break; end
      @(posedge clock);
      #1;
      cyc++;
    end
    check({tag, " done_seen"}, seen, 1);
    check({tag, " latency"}, cyc, e_lat);
    check({tag, " operand"}, operand, e_op);
    check({tag, " addr_err"}, addr_err, e_err);
    check({tag, " rd_count"}, nrd, e_rd);
    check({tag, " wr_count"}, nwr, e_wr);
    check({tag, " rd_wr_overlap"}, both, 0);
    if (e_wr != 0) begin
      check({tag, " wr_addr"}, obs_waddr, e_waddr);
      check({tag, " wr_data"}, obs_wd, e_wd);
    end
    @(posedge clock);
    #1;
    start = 1'b0;
    check({tag, " idle_after"}, {busy, done}, 2'b00);
    check({tag, " operand_held"}, operand, e_op);
  endtask

  initial begin
    // Reset state
    #2;
    check("reset_outputs", {ram_addr, ram_rd, ram_wr, ram_wdata, operand, busy, done, addr_err}, 0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 128; i++) preload(7'(i), 8'($urandom_range(0, 255)));

    // Register read at bank 2, R5
    preload(7'h15, 8'h3C);
    run("rd_reg", 4'd1, 2'd2, 3'd5, 8'h00, 8'h00, 8'h00, 1'b0);
    check("rd_reg first_rd_addr", first_rd_addr, 8'h15);

    // MOV @R1,A in bank 0
    preload(7'h01, 8'h40);
    run("wr_ind", 4'd4, 2'd0, 3'd1, 8'h00, 8'h00, 8'hA5, 1'b0);
    check("wr_ind ptr_addr", first_rd_addr, 8'h01);

    // Pointer out of range
    preload(7'h00, 8'h90);
    run("ind_err", 4'd3, 2'd0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0);

    // Immediate
    run("imm", 4'd6, 2'd1, 3'd3, 8'h00, 8'h7F, 8'h00, 1'b0);

    // Start held high throughout a 5-cycle indirect read
    preload(7'h09, 8'h22);
    preload(7'h22, 8'h5A);
    run("busy_ind", 4'd3, 2'd1, 3'd1, 8'h00, 8'h00, 8'h00, 1'b1);

    // SFR-space direct address and no-op codes
    run("sfr_rd", 4'd5, 2'd0, 3'd0, 8'h85, 8'h00, 8'h00, 1'b0);
    run("sfr_wr", 4'd7, 2'd0, 3'd0, 8'hF0, 8'h00, 8'h33, 1'b0);
    run("imm2", 4'd6, 2'd0, 3'd0, 8'h00, 8'hC3, 8'h00, 1'b0);
    run("none", 4'd0, 2'd0, 3'd0, 8'h00, 8'h11, 8'h00, 1'b0);
    run("code12", 4'd12, 2'd3, 3'd7, 8'h00, 8'h22, 8'h00, 1'b0);

    // Reset while the write strobe is up
    preload(7'h30, 8'h11);
    ram_access = 4'd7; direct_addr = 8'h30; acc_in = 8'hEE; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    check("rst_wr strobe_up", ram_wr, 1);
    reset = 1'b0;
    #1;
    check("rst_wr outputs", {ram_addr, ram_rd, ram_wr, ram_wdata, operand, busy, done, addr_err}, 0);
    @(negedge clock);
    reset = 1'b1;
    exp_operand = 8'h00;
    @(posedge clock);
    #1;
    check("post_rst idle", {busy, done, ram_rd, ram_wr}, 0);
    run("post_rst rd", 4'd5, 2'd0, 3'd0, 8'h30, 8'h00, 8'h00, 1'b0);

    // Random transactions
    for (int n = 0; n < 150; n++) begin
      run("rand", 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
          3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
          8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    // Whole-RAM image against the model
    begin
      int diff;
      diff = 0;
      for (int i = 0; i < 128; i++) if (mem[i] !== shadow[i]) diff++;
      check("ram_image", diff, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
